// File: rtl/m_col_search_scheduler_pkg.sv
// rtl/m_col_search_scheduler_pkg.sv - shared constants, state encoding and board helpers for the column search
package m_col_search_scheduler_pkg;

  localparam int N_COLS     = 7;
  localparam int N_ROWS     = 6;
  localparam int SCORE_W    = 16;
  localparam int TIMEOUT    = 4095;
  localparam int FIELD_SIZE = 42;
  localparam int PILED_W    = 21;
  localparam int CNT_W      = 12;

  localparam logic [2:0]               DEFAULT_COL = 3'd3;
  localparam logic [2:0]               ROWS_FULL   = 3'(N_ROWS);
  localparam logic [2:0]               SLOT_LAST   = 3'(N_COLS - 1);
  localparam logic [CNT_W-1:0]         CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic signed [SCORE_W-1:0] SCORE_MIN  = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  function automatic logic [2:0] piled_count(input logic [PILED_W-1:0] arr, input logic [2:0] col);
    return arr[int'(col)*3 +: 3];
  endfunction

endpackage

// File: rtl/m_col_search_scheduler_if.sv
// rtl/m_col_search_scheduler_if.sv - request/result handshake between the scheduler and the column evaluator
interface m_col_search_scheduler_if
  import m_col_search_scheduler_pkg::*;
();
  logic                        o_eval_req;
  logic [2:0]                  o_eval_col;
  logic [FIELD_SIZE-1:0]       o_eval_me;
  logic [FIELD_SIZE-1:0]       o_eval_op;
  logic                        i_eval_valid;
  logic signed [SCORE_W-1:0]   i_eval_score;

  modport master (
    output o_eval_req, o_eval_col, o_eval_me, o_eval_op,
    input  i_eval_valid, i_eval_score
  );

  modport slave (
    input  o_eval_req, o_eval_col, o_eval_me, o_eval_op,
    output i_eval_valid, i_eval_score
  );
endinterface

// File: rtl/m_search_order_rom.sv
// rtl/m_search_order_rom.sv - centre-first slot to column map (3,2,4,1,5,0,6)
module m_search_order_rom (
  input  logic [2:0] i_slot,
  output logic [2:0] o_col
);
  always_comb begin
    o_col = 3'd3;
    case (i_slot)
      3'd0:    o_col = 3'd3;
      3'd1:    o_col = 3'd2;
      3'd2:    o_col = 3'd4;
      3'd3:    o_col = 3'd1;
      3'd4:    o_col = 3'd5;
      3'd5:    o_col = 3'd0;
      3'd6:    o_col = 3'd6;
      default: o_col = 3'd3;
    endcase
  end
endmodule

// File: rtl/m_col_search_scheduler.sv
// rtl/m_col_search_scheduler.sv - walks legal columns through one shared evaluator and keeps the best signed score
module m_col_search_scheduler
  import m_col_search_scheduler_pkg::*;
(
  input  logic                        w_clk,
  input  logic                        w_rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [FIELD_SIZE-1:0]       i_me_field,
  input  logic [FIELD_SIZE-1:0]       i_op_field,
  input  logic [PILED_W-1:0]          i_piled_array,
  m_col_search_scheduler_if.master    eval_if,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [2:0]                  o_best_col,
  output logic signed [SCORE_W-1:0]   o_best_score,
  output logic                        o_no_legal,
  output logic                        o_timeout
);
  state_t                      r_state;
  state_t                      w_next;
  logic [2:0]                  r_slot;
  logic [2:0]                  w_col;
  logic [PILED_W-1:0]          r_piled;
  logic [FIELD_SIZE-1:0]       r_me;
  logic [FIELD_SIZE-1:0]       r_op;
  logic [CNT_W-1:0]            r_wait_cnt;
  logic                        r_found;
  logic [2:0]                  r_run_col;
  logic signed [SCORE_W-1:0]   r_run_score;
  logic                        w_active;
  logic                        w_hit;
  logic                        w_expire;
  logic                        w_col_full;

  m_search_order_rom u_order (
    .i_slot (r_slot),
    .o_col  (w_col)
  );

  assign w_col_full = piled_count(r_piled, w_col) >= ROWS_FULL;
  assign w_active   = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_hit      = w_active && eval_if.i_eval_valid;
  assign w_expire   = w_active && !eval_if.i_eval_valid && (r_wait_cnt == CNT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CHECK;
      S_CHECK: w_next = w_col_full ? S_NEXT : S_REQ;
      S_REQ,
      S_WAIT:  w_next = (w_hit || w_expire) ? S_NEXT : S_WAIT;
      S_NEXT:  w_next = (r_slot == SLOT_LAST) ? S_DONE : S_CHECK;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort overrides every transition, including a start seen in IDLE.
    if (i_abort) w_next = S_IDLE;
  end

  assign eval_if.o_eval_req = w_active && !i_abort;
  assign eval_if.o_eval_col = w_col;
  assign eval_if.o_eval_me  = r_me;
  assign eval_if.o_eval_op  = r_op;
  assign o_busy             = (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_piled      <= '0;
      r_me         <= '0;
      r_op         <= '0;
      r_wait_cnt   <= '0;
      r_found      <= 1'b0;
      r_run_col    <= DEFAULT_COL;
      r_run_score  <= SCORE_MIN;
      o_done       <= 1'b0;
      o_best_col   <= DEFAULT_COL;
      o_best_score <= SCORE_MIN;
      o_no_legal   <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      r_state <= w_next;
      o_done  <= (w_next == S_DONE);

      if ((r_state == S_IDLE) && (w_next == S_CHECK)) begin
        r_piled     <= i_piled_array;
        r_me        <= i_me_field;
        r_op        <= i_op_field;
        r_slot      <= '0;
        r_found     <= 1'b0;
        r_run_col   <= DEFAULT_COL;
        r_run_score <= SCORE_MIN;
        o_timeout   <= 1'b0;
        o_no_legal  <= 1'b0;
      end

      if (w_next == S_REQ) begin
        r_wait_cnt <= '0;
      end else if (w_active) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      // Strict greater-than keeps the earlier (more central) column on ties.
      if (w_hit && !i_abort && (!r_found || (eval_if.i_eval_score > r_run_score))) begin
        r_found     <= 1'b1;
        r_run_col   <= w_col;
        r_run_score <= eval_if.i_eval_score;
      end

      if (w_expire && !i_abort) o_timeout <= 1'b1;

      if ((r_state == S_NEXT) && (w_next == S_CHECK)) r_slot <= r_slot + 1'b1;

      if (w_next == S_DONE) begin
        o_best_col   <= r_found ? r_run_col : DEFAULT_COL;
        o_best_score <= r_found ? r_run_score : SCORE_MIN;
        o_no_legal   <= !r_found;
      end
    end
  end
endmodule

// File: tb/tb_m_col_search_scheduler.sv
// tb/tb_m_col_search_scheduler.sv - directed scoreboard bench for the centre-first column search scheduler
module tb_m_col_search_scheduler;
  import m_col_search_scheduler_pkg::*;

  localparam int LAT = 2;

  typedef struct {
    logic [2:0]          col;
    logic signed [15:0]  score;
    logic                nl;
    logic                to;
  } res_t;

  logic               w_clk = 1'b0;
  logic               w_rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic               i_abort = 1'b0;
  logic [41:0]        i_me_field = '0;
  logic [41:0]        i_op_field = '0;
  logic [20:0]        i_piled_array = '0;
  logic               o_busy;
  logic               o_done;
  logic [2:0]         o_best_col;
  logic signed [15:0] o_best_score;
  logic               o_no_legal;
  logic               o_timeout;

  m_col_search_scheduler_if u_if ();

  m_col_search_scheduler dut (
    .w_clk         (w_clk),
    .w_rst_n       (w_rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_me_field    (i_me_field),
    .i_op_field    (i_op_field),
    .i_piled_array (i_piled_array),
    .eval_if       (u_if),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_best_col    (o_best_col),
    .o_best_score  (o_best_score),
    .o_no_legal    (o_no_legal),
    .o_timeout     (o_timeout)
  );

  always #5 w_clk = ~w_clk;

  int                 checks = 0;
  int                 errors = 0;
  int                 cyc = 0;
  int                 done_cnt = 0;
  int                 done_cyc = 0;
  int                 start_cyc = 0;
  int                 base = 0;
  int                 dur_col = -1;
  int                 ev_lat = 0;
  int                 req_len = 0;
  logic               prev_req = 1'b0;
  logic [2:0]         prev_col = '0;
  logic [2:0]         exp_req_q[$];
  res_t               exp_res_q[$];
  res_t               mon_r;
  logic [2:0]         mon_e;
  logic signed [15:0] tab[7];
  logic               silent[7];
  logic [41:0]        snap_me = '0;
  logic [41:0]        snap_op = '0;

  always @(posedge w_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_order(input int n);
    logic [2:0] order[7];
    order = '{3'd3, 3'd2, 3'd4, 3'd1, 3'd5, 3'd0, 3'd6};
    for (int i = 0; i < n; i++) exp_req_q.push_back(order[i]);
  endtask

  task automatic push_res(input logic [2:0] c, input logic signed [15:0] s, input logic nl, input logic to);
    res_t r;
    r.col = c; r.score = s; r.nl = nl; r.to = to;
    exp_res_q.push_back(r);
  endtask

  task automatic start_search(input logic [20:0] piled, input logic [41:0] me, input logic [41:0] op);
    @(negedge w_clk);
    base          = done_cnt;
    i_piled_array = piled;
    i_me_field    = me;
    i_op_field    = op;
    snap_me       = me;
    snap_op       = op;
    i_start       = 1'b1;
    start_cyc     = cyc;
    @(negedge w_clk);
    i_start       = 1'b0;
    i_me_field    = ~me;
    i_op_field    = ~op;
    i_piled_array = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (i < budget && done_cnt == base) begin
      @(negedge w_clk);
      #2;
      i++;
    end
    if (done_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL %s: no o_done within %0d cycles", name, budget);
    end
  endtask

  // Evaluator model: answers LAT cycles after req rises unless the column is silent.
  initial begin
    u_if.i_eval_valid = 1'b0;
    u_if.i_eval_score = '0;
    forever begin
      @(negedge w_clk);
      #1;
      if (u_if.o_eval_req) begin
        ev_lat++;
        if (!silent[u_if.o_eval_col] && ev_lat == LAT) begin
          u_if.i_eval_valid = 1'b1;
          u_if.i_eval_score = tab[u_if.o_eval_col];
        end else begin
          u_if.i_eval_valid = 1'b0;
        end
      end else begin
        ev_lat = 0;
        u_if.i_eval_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge w_clk);
      #1;
      if (!w_rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (u_if.o_eval_req && !prev_req) begin
          if (exp_req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: col %0d requested, none expected", u_if.o_eval_col);
          end else begin
            mon_e = exp_req_q.pop_front();
            chk("req_col", u_if.o_eval_col, mon_e);
            chk("eval_me_snapshot", u_if.o_eval_me, snap_me);
            chk("eval_op_snapshot", u_if.o_eval_op, snap_op);
          end
          req_len = 0;
        end
        if (u_if.o_eval_req) req_len++;
        if (!u_if.o_eval_req && prev_req && int'(prev_col) == dur_col)
          chk("timeout_req_cycles", req_len, TIMEOUT);
        if (o_done) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: o_done with best_col %0d", o_best_col);
          end else begin
            mon_r = exp_res_q.pop_front();
            chk("best_col", o_best_col, mon_r.col);
            chk("best_score", o_best_score, mon_r.score);
            chk("no_legal", o_no_legal, mon_r.nl);
            chk("timeout_flag", o_timeout, mon_r.to);
            chk("busy_in_done", o_busy, 0);
          end
        end
        prev_req = u_if.o_eval_req;
        prev_col = u_if.o_eval_col;
      end
    end
  end

  initial begin
    for (int c = 0; c < 7; c++) begin
      tab[c] = '0;
      silent[c] = 1'b0;
    end
    repeat (3) @(negedge w_clk);
    chk("rst_best_col", o_best_col, 3);
    chk("rst_best_score", o_best_score, -32768);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_no_legal", o_no_legal, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_req", u_if.o_eval_req, 0);
    w_rst_n = 1'b1;

    // 1: scores col*10
    for (int c = 0; c < 7; c++) tab[c] = 16'(c * 10);
    push_order(7);
    push_res(3'd6, 16'sd60, 1'b0, 1'b0);
    start_search('0, 42'h0123456789a, 42'h3a5a5a5a5a5);
    @(negedge w_clk);
    #2;
    chk("busy_after_start", o_busy, 1);
    wait_done("t1", 300);

    // 2: all equal scores resolve to the centre
    for (int c = 0; c < 7; c++) tab[c] = 16'sd5;
    push_order(7);
    push_res(3'd3, 16'sd5, 1'b0, 1'b0);
    start_search('0, 42'h00000000fff, 42'h3ff00000000);
    wait_done("t2", 300);

    // 3: board full
    push_res(3'd3, -16'sd32768, 1'b1, 1'b0);
    start_search({7{3'd6}}, 42'h15555555555, 42'h2aaaaaaaaaa);
    wait_done("t3", 100);
    chk("full_board_latency", done_cyc - start_cyc, 15);

    // 4: col3 full, col1 one short of full, col0 is the only positive score
    for (int c = 0; c < 7; c++) tab[c] = -16'sd1;
    tab[0] = 16'sd7;
    exp_req_q.push_back(3'd2);
    exp_req_q.push_back(3'd4);
    exp_req_q.push_back(3'd1);
    exp_req_q.push_back(3'd5);
    exp_req_q.push_back(3'd0);
    exp_req_q.push_back(3'd6);
    push_res(3'd0, 16'sd7, 1'b0, 1'b0);
    start_search({3'd0, 3'd0, 3'd0, 3'd6, 3'd0, 3'd5, 3'd0}, 42'h00000000008, 42'h00000000001);
    wait_done("t4", 300);

    // 5: col2 never answers
    for (int c = 0; c < 7; c++) tab[c] = 16'sd1;
    tab[5] = 16'sd3;
    tab[2] = 16'sd100;
    silent[2] = 1'b1;
    dur_col = 2;
    push_order(7);
    push_res(3'd5, 16'sd3, 1'b0, 1'b1);
    start_search('0, 42'h1, 42'h2);
    wait_done("t5", 6000);
    dur_col = -1;
    silent[2] = 1'b0;

    // 6: abort while waiting on slot 4 (col 5)
    silent[5] = 1'b1;
    push_order(5);
    start_search('0, 42'h3, 42'h4);
    for (int i = 0; i < 200 && !(u_if.o_eval_req && u_if.o_eval_col == 3'd5); i++) begin
      @(negedge w_clk);
      #2;
    end
    chk("reached_slot4_req", u_if.o_eval_req && u_if.o_eval_col == 3'd5, 1);
    @(negedge w_clk);
    i_abort = 1'b1;
    #1;
    chk("abort_req_same_cycle", u_if.o_eval_req, 0);
    @(negedge w_clk);
    i_abort = 1'b0;
    #2;
    chk("abort_req_next_cycle", u_if.o_eval_req, 0);
    chk("abort_busy", o_busy, 0);
    repeat (30) @(negedge w_clk);
    #2;
    chk("abort_no_done", done_cnt, base);
    chk("abort_keeps_col", o_best_col, 5);
    chk("abort_keeps_score", o_best_score, 3);
    silent[5] = 1'b0;

    // 7: start and abort together in IDLE
    @(negedge w_clk);
    base = done_cnt;
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge w_clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    #2;
    chk("start_abort_busy", o_busy, 0);
    repeat (20) @(negedge w_clk);
    #2;
    chk("start_abort_no_done", done_cnt, base);

    chk("req_queue_drained", exp_req_q.size(), 0);
    chk("res_queue_drained", exp_res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
